// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver (5..9 data bits, optional parity, 1/2 stop bits)
// with majority-voted sampling and a first-word-fall-through output FIFO.
module uart_rx_cfg #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD_RATE   = 115_200,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bit_in,
    output logic [DATA_BITS-1:0] byte_out_data,
    output logic [1:0]           byte_out_err,
    output logic                 byte_out_valid,
    input  logic                 byte_out_ready,
    output logic                 overflow
);

    localparam int TPB  = CLK_FREQ_HZ / BAUD_RATE;
    localparam int HALF = (TPB - 1) / 2;
    localparam int CW   = $clog2(TPB) + 1;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int WW   = DATA_BITS + 2;

    localparam logic [CW-1:0] LAST_TICK = CW'(TPB - 1);
    localparam logic [CW-1:0] HALF_TICK = CW'(HALF);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

    generate
        if (TPB < 8) begin : g_bad_tpb
            $error("uart_rx_cfg: CLK_FREQ_HZ/BAUD_RATE must be at least 8");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
            $error("uart_rx_cfg: DATA_BITS must be 5..9");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_par
            $error("uart_rx_cfg: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_rx_cfg: FIFO_DEPTH must be a power of two >= 2");
        end
    endgenerate

    typedef enum logic [2:0] {HUNT, IDLE, START, DATA, PAR, STOP} state_t;

    logic                 sync1_q, sync2_q;
    logic [1:0]           hist_q, hist_d;
    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_err_q, par_err_d;
    logic                 frm_err_q, frm_err_d;
    logic                 push_q, push_d;
    logic [WW-1:0]        push_word_q, push_word_d;
    logic [AW:0]          wr_ptr_q, wr_ptr_d;
    logic [AW:0]          rd_ptr_q, rd_ptr_d;
    logic [WW-1:0]        mem [FIFO_DEPTH];

    logic rxs, vote, par_calc, frm_now;
    logic empty, full, pop, accept;
    logic [WW-1:0] head;

    assign rxs      = sync2_q;
    // hist_q holds rxs from the two cycles before the current one
    assign vote     = (rxs & hist_q[0]) | (rxs & hist_q[1]) | (hist_q[0] & hist_q[1]);
    assign par_calc = ^{shift_q, vote};
    assign frm_now  = frm_err_q | ~vote;

    always_comb begin
        hist_d      = {hist_q[0], rxs};
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        par_err_d   = par_err_q;
        frm_err_d   = frm_err_q;
        push_d      = 1'b0;
        push_word_d = push_word_q;
        case (state_q)
            HUNT: begin
                if (!rxs) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST_TICK) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            IDLE: begin
                cnt_d = '0;
                if (!rxs) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_TICK) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = vote ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == LAST_TICK) begin
                    cnt_d   = '0;
                    shift_d = {vote, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + 4'd1;
                    if (bit_q == LAST_DATA) begin
                        bit_d     = '0;
                        par_err_d = 1'b0;
                        frm_err_d = 1'b0;
                        state_d   = (PARITY != 0) ? PAR : STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PAR: begin
                if (cnt_q == LAST_TICK) begin
                    cnt_d     = '0;
                    par_err_d = (PARITY == 2) ? ~par_calc : par_calc;
                    state_d   = STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (cnt_q == LAST_TICK) begin
                    cnt_d     = '0;
                    frm_err_d = frm_now;
                    bit_d     = bit_q + 4'd1;
                    if (bit_q == LAST_STOP) begin
                        bit_d       = '0;
                        push_d      = 1'b1;
                        push_word_d = {par_err_q, frm_now, shift_q};
                        // a bad stop bit means we may be misaligned: re-qualify the idle line
                        state_d     = frm_now ? HUNT : IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = HUNT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            hist_q      <= 2'b11;
            state_q     <= HUNT;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            par_err_q   <= 1'b0;
            frm_err_q   <= 1'b0;
            push_q      <= 1'b0;
            push_word_q <= '0;
        end else begin
            sync1_q     <= bit_in;
            sync2_q     <= sync1_q;
            hist_q      <= hist_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            par_err_q   <= par_err_d;
            frm_err_q   <= frm_err_d;
            push_q      <= push_d;
            push_word_q <= push_word_d;
        end
    end

    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop    = !empty && byte_out_ready;
    // a full FIFO still takes the word if the head leaves in the same cycle
    assign accept = push_q && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(accept);
        rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr_q[AW-1:0]] <= push_word_q;
    end

    assign head           = mem[rd_ptr_q[AW-1:0]];
    assign byte_out_valid = !empty;
    assign byte_out_data  = empty ? '0 : head[DATA_BITS-1:0];
    assign byte_out_err   = empty ? '0 : head[WW-1:DATA_BITS];
    assign overflow       = push_q && !accept;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: three instances (8N1 depth 4, 8E1, 8N2)
// at 100 cycles per bit, each scenario in its own task.
module tb_uart_rx_cfg;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] line = 3'b111;
    logic [2:0] rdy = 3'b000;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    logic [7:0] da, db, dc;
    logic [1:0] ea, eb, ec;
    logic       va, vb, vc, ova, ovb, ovc;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_cfg #(.CLK_FREQ_HZ(100_000_000), .BAUD_RATE(1_000_000), .DATA_BITS(8),
                  .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
        .clk(clk), .rst(rst), .bit_in(line[0]), .byte_out_data(da), .byte_out_err(ea),
        .byte_out_valid(va), .byte_out_ready(rdy[0]), .overflow(ova));
    uart_rx_cfg #(.CLK_FREQ_HZ(100_000_000), .BAUD_RATE(1_000_000), .DATA_BITS(8),
                  .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)) u_b (
        .clk(clk), .rst(rst), .bit_in(line[1]), .byte_out_data(db), .byte_out_err(eb),
        .byte_out_valid(vb), .byte_out_ready(rdy[1]), .overflow(ovb));
    uart_rx_cfg #(.CLK_FREQ_HZ(100_000_000), .BAUD_RATE(1_000_000), .DATA_BITS(8),
                  .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(16)) u_c (
        .clk(clk), .rst(rst), .bit_in(line[2]), .byte_out_data(dc), .byte_out_err(ec),
        .byte_out_valid(vc), .byte_out_ready(rdy[2]), .overflow(ovc));

    // Accepted words, {err, data}, collected just after each falling edge.
    logic [9:0] qa[$], qb[$], qc[$];
    int   rise_a = -1, ov_cnt_a = 0, ov_cyc_a = -1, ov_cnt_bc = 0;
    logic va_prev = 1'b0;

    always @(negedge clk) begin
        #1;
        if (va && rdy[0]) qa.push_back({ea, da});
        if (vb && rdy[1]) qb.push_back({eb, db});
        if (vc && rdy[2]) qc.push_back({ec, dc});
        if (va && !va_prev) rise_a = cyc;
        va_prev = va;
        if (ova) begin ov_cnt_a++; ov_cyc_a = cyc; end
        if (ovb || ovc) ov_cnt_bc++;
    end

    function automatic logic [15:0] f8n1(input logic [7:0] d);
        return {6'b0, 1'b1, d, 1'b0};
    endfunction

    // Bit i of bits is held for 100 cycles; t0 is cyc when the start bit is driven.
    task automatic send(input int w, input int nb, input logic [15:0] bits, output int t0);
        t0 = 0;
        for (int i = 0; i < nb; i++) begin
            @(negedge clk);
            line[w] = bits[i];
            if (i == 0) t0 = cyc;
            repeat (99) @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks += 6;
        if (va !== 1'b0)    begin errors++; $display("FAIL reset_valid_a: got %b want 0", va); end
        if (da !== 8'h00)   begin errors++; $display("FAIL reset_data_a: got %h want 00", da); end
        if (ea !== 2'b00)   begin errors++; $display("FAIL reset_err_a: got %b want 00", ea); end
        if (ova !== 1'b0)   begin errors++; $display("FAIL reset_ovf_a: got %b want 0", ova); end
        if (vb !== 1'b0)    begin errors++; $display("FAIL reset_valid_b: got %b want 0", vb); end
        if (vc !== 1'b0)    begin errors++; $display("FAIL reset_valid_c: got %b want 0", vc); end
        rst = 1'b0;
        idle(150);
    endtask

    task automatic test_8n1();
        int t0;
        logic [9:0] w;
        rdy[0] = 1'b1;
        qa.delete();
        send(0, 10, f8n1(8'hA5), t0);
        idle(200);
        w = (qa.size() > 0) ? qa[0] : 10'h3ff;
        checks += 3;
        if (qa.size() != 1)        begin errors++; $display("FAIL 8n1_count: got %0d want 1", qa.size()); end
        if (w !== {2'b00, 8'hA5})  begin errors++; $display("FAIL 8n1_word: got %h want 0a5", w); end
        if (rise_a != t0 + 954)    begin errors++; $display("FAIL 8n1_latency: got %0d want %0d", rise_a, t0 + 954); end
    endtask

    task automatic test_parity();
        int t0;
        logic [9:0] w0, w1;
        rdy[1] = 1'b1;
        qb.delete();
        send(1, 11, {5'b0, 1'b1, 1'b1, 8'h03, 1'b0}, t0);
        idle(150);
        send(1, 11, {5'b0, 1'b1, 1'b0, 8'h03, 1'b0}, t0);
        idle(200);
        w0 = (qb.size() > 0) ? qb[0] : 10'h3ff;
        w1 = (qb.size() > 1) ? qb[1] : 10'h3ff;
        checks += 3;
        if (qb.size() != 2)         begin errors++; $display("FAIL par_count: got %0d want 2", qb.size()); end
        if (w0 !== {2'b10, 8'h03})  begin errors++; $display("FAIL par_bad_word: got %h want 203", w0); end
        if (w1 !== {2'b00, 8'h03})  begin errors++; $display("FAIL par_good_word: got %h want 003", w1); end
    endtask

    task automatic test_stop_err();
        int t0;
        logic [9:0] w0, w1;
        rdy[2] = 1'b1;
        qc.delete();
        send(2, 11, {5'b0, 1'b0, 1'b1, 8'h81, 1'b0}, t0);
        @(negedge clk);
        line[2] = 1'b1;
        idle(40);
        // falls while the receiver is still re-qualifying the idle line
        send(2, 10, f8n1(8'h00), t0);
        idle(300);
        send(2, 11, {5'b0, 1'b1, 1'b1, 8'h3C, 1'b0}, t0);
        idle(200);
        w0 = (qc.size() > 0) ? qc[0] : 10'h3ff;
        w1 = (qc.size() > 1) ? qc[1] : 10'h3ff;
        checks += 4;
        if (qc.size() != 2)         begin errors++; $display("FAIL stop_count: got %0d want 2", qc.size()); end
        if (w0 !== {2'b01, 8'h81})  begin errors++; $display("FAIL stop_err_word: got %h want 181", w0); end
        if (w1 !== {2'b00, 8'h3C})  begin errors++; $display("FAIL stop_after_hunt: got %h want 03c", w1); end
        if (ov_cnt_bc != 0)         begin errors++; $display("FAIL bc_overflow: got %0d want 0", ov_cnt_bc); end
    endtask

    task automatic test_glitch();
        int t0;
        logic [9:0] w;
        rdy[0] = 1'b1;
        qa.delete();
        ov_cnt_a = 0;
        @(negedge clk);
        line[0] = 1'b0;
        idle(30);
        line[0] = 1'b1;
        idle(300);
        checks += 2;
        if (qa.size() != 0)  begin errors++; $display("FAIL glitch_word: got %0d words want 0", qa.size()); end
        if (ov_cnt_a != 0)   begin errors++; $display("FAIL glitch_ovf: got %0d want 0", ov_cnt_a); end
        send(0, 10, f8n1(8'h5A), t0);
        idle(200);
        w = (qa.size() > 0) ? qa[0] : 10'h3ff;
        checks += 2;
        if (qa.size() != 1)        begin errors++; $display("FAIL glitch_next_count: got %0d want 1", qa.size()); end
        if (w !== {2'b00, 8'h5A})  begin errors++; $display("FAIL glitch_next_word: got %h want 05a", w); end
    endtask

    task automatic test_back_to_back();
        int t[5];
        logic [9:0] w;
        rdy[0] = 1'b0;
        qa.delete();
        ov_cnt_a = 0;
        for (int k = 0; k < 5; k++) send(0, 10, f8n1(8'(8'h11 + k)), t[k]);
        idle(100);
        checks += 5;
        if (ov_cnt_a != 1)          begin errors++; $display("FAIL ovf_count: got %0d want 1", ov_cnt_a); end
        if (ov_cyc_a != t[4] + 953) begin errors++; $display("FAIL ovf_cycle: got %0d want %0d", ov_cyc_a, t[4] + 953); end
        if (va !== 1'b1)            begin errors++; $display("FAIL full_valid: got %b want 1", va); end
        if (da !== 8'h11)           begin errors++; $display("FAIL full_head: got %h want 11", da); end
        if (ea !== 2'b00)           begin errors++; $display("FAIL full_head_err: got %b want 00", ea); end
        @(negedge clk);
        rdy[0] = 1'b1;
        idle(10);
        rdy[0] = 1'b0;
        checks += 2;
        if (qa.size() != 4) begin errors++; $display("FAIL drain_count: got %0d want 4", qa.size()); end
        if (va !== 1'b0)    begin errors++; $display("FAIL drain_valid: got %b want 0", va); end
        for (int k = 0; k < 4; k++) begin
            w = (qa.size() > k) ? qa[k] : 10'h3ff;
            checks++;
            if (w !== {2'b00, 8'(8'h11 + k)}) begin
                errors++; $display("FAIL drain_word%0d: got %h want %h", k, w, {2'b00, 8'(8'h11 + k)});
            end
        end
    endtask

    task automatic test_reset_mid();
        int t0;
        logic [9:0] w;
        rdy[0] = 1'b1;
        qa.delete();
        // start bit plus the first three data bits of 0x77
        send(0, 4, {12'b0, 3'b111, 1'b0}, t0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        line[0] = 1'b1;
        idle(1500);
        checks += 2;
        if (qa.size() != 0) begin errors++; $display("FAIL rst_mid_words: got %0d want 0", qa.size()); end
        if (va !== 1'b0)    begin errors++; $display("FAIL rst_mid_valid: got %b want 0", va); end
        send(0, 10, f8n1(8'h3C), t0);
        idle(200);
        w = (qa.size() > 0) ? qa[0] : 10'h3ff;
        checks++;
        if (w !== {2'b00, 8'h3C}) begin errors++; $display("FAIL rst_mid_next: got %h want 03c", w); end
    endtask

    task automatic test_reset_flush();
        int t0;
        rdy[0] = 1'b0;
        qa.delete();
        send(0, 10, f8n1(8'h42), t0);
        idle(100);
        checks++;
        if (va !== 1'b1) begin errors++; $display("FAIL flush_pre_valid: got %b want 1", va); end
        rst = 1'b1;
        @(negedge clk);
        checks += 2;
        if (va !== 1'b0)  begin errors++; $display("FAIL flush_valid: got %b want 0", va); end
        if (da !== 8'h00) begin errors++; $display("FAIL flush_data: got %h want 00", da); end
        rst = 1'b0;
        rdy[0] = 1'b1;
        idle(50);
        checks++;
        if (qa.size() != 0) begin errors++; $display("FAIL flush_words: got %0d want 0", qa.size()); end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_stop_err();
        test_glitch();
        test_back_to_back();
        test_reset_mid();
        test_reset_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver that replaces the fixed 8N1 receiver in the debug serial path. It supports 5–9 data bits, optional even/odd parity and 1 or 2 stop bits, and takes a majority-voted mid-bit sample. Each received word is tagged with parity and framing error flags. Words are buffered in an internal first-word-fall-through FIFO and presented on a valid/ready stream to the command parser.

## Interface
- CLK_FREQ_HZ, 100_000_000, system clock frequency.
- BAUD_RATE, 115_200, line rate. TICKS_PER_BIT = floor(CLK_FREQ_HZ/BAUD_RATE). Elaboration error if TICKS_PER_BIT < 8.
- DATA_BITS, 8, data bits per frame, 5..9, LSB first.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, 1 or 2.
- FIFO_DEPTH, 16, word count; power of two, ≥ 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- bit_in  in  1  asynchronous serial line; idles high.
- byte_out_data  out  DATA_BITS  head-of-FIFO data word.
- byte_out_err  out  2  head-of-FIFO flags: [1] parity_err, [0] frame_err.
- byte_out_valid  out  1  FIFO non-empty.
- byte_out_ready  in  1  consumer accepts the head word when high together with valid.
- overflow  out  1  one-cycle pulse when a completed frame is dropped because the FIFO is full.

## Operation
- bit_in passes through a 2-flop synchronizer; all logic uses the synchronized line `rxs`.
- Sampling uses a majority vote of 3: the values of `rxs` at the sample-point cycle and the 2 preceding cycles.
- The tick counter is `$clog2(TICKS_PER_BIT)+1` bits wide and resets to 0 on every state transition.
- HALF = (TICKS_PER_BIT-1)/2, integer division.

State machine (reset state HUNT):
- HUNT: requires `rxs` = 1 for TICKS_PER_BIT consecutive cycles. Any 0 restarts the count. When the count completes → IDLE.
- IDLE: `rxs` = 0 → START.
- START: at counter = HALF, vote 0 → DATA; vote 1 → IDLE (glitch, nothing written).
- DATA: sample at counter = TICKS_PER_BIT-1 and shift in LSB first. After DATA_BITS samples → PARITY if PARITY≠0, otherwise STOP.
- PARITY: sample at counter = TICKS_PER_BIT-1. parity_err = 1 when the XOR of data and parity bit ≠ 0 (even) or ≠ 1 (odd). When PARITY = 0, parity_err is forced to 0.
- STOP: sample at counter = TICKS_PER_BIT-1 for each stop bit. frame_err = 1 if any stop sample is 0.
  - After the last stop sample, push {err, data} to the FIFO.
  - frame_err = 0 → IDLE. frame_err = 1 → HUNT.
- Errored words are still delivered; the flags describe that word only.

FIFO:
- A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle. Otherwise the word is dropped and overflow pulses.
- A pop occurs when byte_out_valid && byte_out_ready.
- Read and write pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally; full/empty are decided by MSB comparison.
- Simultaneous push and pop on an empty FIFO: no pop happens (valid is 0); the word is stored.

## Timing
- Sample points: the START vote is at counter = HALF. Each subsequent bit is sampled exactly TICKS_PER_BIT cycles after the previous sample.
- Line-to-state latency: 2 synchronizer cycles.
- Push occurs in the cycle after the final stop sample. byte_out_valid is high in the cycle after the push (FWFT). byte_out_data and byte_out_err are valid in that same cycle.
- byte_out_data and byte_out_err stay stable while valid && !ready. The next word appears in the cycle after a pop.
- The receiver leaves STOP to IDLE right after the last stop sample, so a start edge arriving immediately after is caught.
- Reset values:
  - byte_out_valid = 0, byte_out_data = 0, byte_out_err = 0, overflow = 0.
  - FIFO empty, state HUNT.
  - Synchronizer flops = 1.
- rst mid-frame: the partial frame is discarded and never written. The receiver re-arms via HUNT.
- rst with the FIFO non-empty: all contents are discarded; valid falls in the cycle after rst is sampled.

## Test plan
All scenarios use CLK_FREQ_HZ = 100 MHz and BAUD_RATE = 1 MHz, so TICKS_PER_BIT = 100 and HALF = 49.
- 8N1, idle line for 100 cycles, send 0xA5 → exactly one word 0xA5 with err = 00. valid rises 2 cycles after the stop-bit sample point (1 push cycle + 1 FWFT cycle).
- 8E1, send 0x03 with parity bit 1 → word 0x03, err = 10. Same data with parity bit 0 → err = 00.
- 8N2, second stop bit driven 0 → word with err = 01, state enters HUNT. A start edge within the next 100 high cycles is ignored; a frame after that is received correctly.
- 30-cycle low glitch on an idle line → no word and no overflow; the next valid frame 0x5A is received correctly.
- FIFO_DEPTH = 4, ready held 0, send 0x11..0x15 → 4 words stored, overflow pulses once at the 5th frame's push cycle. Draining with ready = 1 yields 0x11, 0x12, 0x13, 0x14.
- rst asserted for 1 cycle after the 3rd data bit of frame 0x77 → no word and valid stays 0. A frame 0x3C sent after ≥100 idle cycles is received correctly.
